// File: rtl/axi_slave_mem_pkg.sv
// Shared constants and state encodings for the 512-bit AXI slave memory.
package axi_slave_mem_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_64B    = 3'b110;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    function automatic logic [1:0] resp_code(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_slave_mem_if.sv
// Five-channel AXI4 bundle as seen by axi_slave_mem; master drives requests, slave drives responses.
interface axi_slave_mem_if
    import axi_slave_mem_pkg::*;
#(
    parameter int ID_W = 16
);

    logic [ID_W-1:0]   arid_s;
    logic [ADDR_W-1:0] araddr_s;
    logic [7:0]        arlen_s;
    logic [2:0]        arsize_s;
    logic              arvalid_s;
    logic              arready_s;

    logic [ID_W-1:0]   rid_s;
    logic [DATA_W-1:0] rdata_s;
    logic [1:0]        rresp_s;
    logic              rlast_s;
    logic              rvalid_s;
    logic              rready_s;

    logic [ID_W-1:0]   awid_s;
    logic [ADDR_W-1:0] awaddr_s;
    logic [7:0]        awlen_s;
    logic [2:0]        awsize_s;
    logic              awvalid_s;
    logic              awready_s;

    logic [ID_W-1:0]   wid_s;
    logic [DATA_W-1:0] wdata_s;
    logic [STRB_W-1:0] wstrb_s;
    logic              wlast_s;
    logic              wvalid_s;
    logic              wready_s;

    logic [ID_W-1:0]   bid_s;
    logic [1:0]        bresp_s;
    logic              bvalid_s;
    logic              bready_s;

    modport slave (
        input  arid_s, araddr_s, arlen_s, arsize_s, arvalid_s,
        output arready_s,
        output rid_s, rdata_s, rresp_s, rlast_s, rvalid_s,
        input  rready_s,
        input  awid_s, awaddr_s, awlen_s, awsize_s, awvalid_s,
        output awready_s,
        input  wid_s, wdata_s, wstrb_s, wlast_s, wvalid_s,
        output wready_s,
        output bid_s, bresp_s, bvalid_s,
        input  bready_s
    );

    modport master (
        output arid_s, araddr_s, arlen_s, arsize_s, arvalid_s,
        input  arready_s,
        input  rid_s, rdata_s, rresp_s, rlast_s, rvalid_s,
        output rready_s,
        output awid_s, awaddr_s, awlen_s, awsize_s, awvalid_s,
        input  awready_s,
        output wid_s, wdata_s, wstrb_s, wlast_s, wvalid_s,
        input  wready_s,
        input  bid_s, bresp_s, bvalid_s,
        output bready_s
    );

endinterface

// File: rtl/axi_sm_ram.sv
// Word memory: combinational read port, byte-enabled write port committed on the clock edge.
module axi_sm_ram
    import axi_slave_mem_pkg::*;
#(
    parameter int LOG_WORDS = 10
) (
    input  logic                 clk,
    input  logic [LOG_WORDS-1:0] raddr,
    output logic [DATA_W-1:0]    rdata,
    input  logic                 we,
    input  logic [LOG_WORDS-1:0] waddr,
    input  logic [STRB_W-1:0]    wstrb,
    input  logic [DATA_W-1:0]    wdata
);

    logic [DATA_W-1:0] mem [2**LOG_WORDS];

    // A same-cycle write to raddr is only seen after the edge, so the read returns old data.
    assign rdata = mem[raddr];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave over a 2^LOG_WORDS x 512-bit memory; independent read and write engines,
// one outstanding burst per direction, word pointers wrap around the memory.
//
// state   | meaning
// R_IDLE  | waiting for AR, arready high
// R_BURST | presenting read beats until the counted last beat is taken
// W_IDLE  | waiting for AW, awready high
// W_DATA  | accepting write beats until the beat count runs out
// W_RESP  | holding the write response until bready
module axi_slave_mem
    import axi_slave_mem_pkg::*;
#(
    parameter int LOG_WORDS = 10,
    parameter int ID_W      = 16
) (
    input  logic           clk,
    input  logic           rst,
    axi_slave_mem_if.slave bus
);

    rd_state_t            rd_state, rd_state_nxt;
    logic [ID_W-1:0]      rd_id;
    logic [LOG_WORDS-1:0] rd_ptr;
    logic [8:0]           rd_beats;
    logic                 rd_err;
    logic                 ar_hs, r_hs, rd_final;
    logic [DATA_W-1:0]    rd_data;

    wr_state_t            wr_state, wr_state_nxt;
    logic [ID_W-1:0]      wr_id;
    logic [LOG_WORDS-1:0] wr_ptr;
    logic [8:0]           wr_beats;
    logic                 wr_err;
    logic                 aw_hs, w_hs, wr_final;

    logic unused_bits;
    assign unused_bits = ^{bus.wid_s, bus.araddr_s, bus.awaddr_s};

    assign rd_final = (rd_beats == 9'd1);
    assign wr_final = (wr_beats == 9'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= R_IDLE;
            rd_id    <= '0;
            rd_ptr   <= '0;
            rd_beats <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_state <= rd_state_nxt;
            if (ar_hs) begin
                rd_id    <= bus.arid_s;
                rd_ptr   <= bus.araddr_s[LOG_WORDS+5:6];
                rd_beats <= {1'b0, bus.arlen_s} + 9'd1;
                rd_err   <= (bus.arsize_s != SIZE_64B);
            end else if (r_hs) begin
                rd_ptr   <= rd_ptr + LOG_WORDS'(1);
                rd_beats <= rd_beats - 9'd1;
            end
        end
    end

    always_comb begin
        rd_state_nxt  = rd_state;
        ar_hs         = 1'b0;
        r_hs          = 1'b0;
        bus.arready_s = 1'b0;
        bus.rvalid_s  = 1'b0;
        bus.rlast_s   = 1'b0;
        bus.rresp_s   = RESP_OKAY;
        case (rd_state)
            R_IDLE: begin
                bus.arready_s = 1'b1;
                ar_hs         = bus.arvalid_s;
                if (ar_hs) rd_state_nxt = R_BURST;
            end
            R_BURST: begin
                bus.rvalid_s = 1'b1;
                bus.rlast_s  = rd_final;
                bus.rresp_s  = resp_code(rd_err);
                r_hs         = bus.rready_s;
                if (r_hs && rd_final) rd_state_nxt = R_IDLE;
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    assign bus.rid_s   = rd_id;
    assign bus.rdata_s = rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= W_IDLE;
            wr_id    <= '0;
            wr_ptr   <= '0;
            wr_beats <= '0;
            wr_err   <= 1'b0;
        end else begin
            wr_state <= wr_state_nxt;
            if (aw_hs) begin
                wr_id    <= bus.awid_s;
                wr_ptr   <= bus.awaddr_s[LOG_WORDS+5:6];
                wr_beats <= {1'b0, bus.awlen_s} + 9'd1;
                wr_err   <= (bus.awsize_s != SIZE_64B);
            end else if (w_hs) begin
                wr_ptr   <= wr_ptr + LOG_WORDS'(1);
                wr_beats <= wr_beats - 9'd1;
                // wlast is only cross-checked; the beat count alone ends the burst.
                if (bus.wlast_s != wr_final) wr_err <= 1'b1;
            end
        end
    end

    always_comb begin
        wr_state_nxt  = wr_state;
        aw_hs         = 1'b0;
        w_hs          = 1'b0;
        bus.awready_s = 1'b0;
        bus.wready_s  = 1'b0;
        bus.bvalid_s  = 1'b0;
        bus.bresp_s   = RESP_OKAY;
        case (wr_state)
            W_IDLE: begin
                bus.awready_s = 1'b1;
                aw_hs         = bus.awvalid_s;
                if (aw_hs) wr_state_nxt = W_DATA;
            end
            W_DATA: begin
                bus.wready_s = 1'b1;
                w_hs         = bus.wvalid_s;
                if (w_hs && wr_final) wr_state_nxt = W_RESP;
            end
            W_RESP: begin
                bus.bvalid_s = 1'b1;
                bus.bresp_s  = resp_code(wr_err);
                if (bus.bready_s) wr_state_nxt = W_IDLE;
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    assign bus.bid_s = wr_id;

    // Reset aborts a burst without committing the beat presented in the reset cycle.
    axi_sm_ram #(
        .LOG_WORDS(LOG_WORDS)
    ) u_ram (
        .clk   (clk),
        .raddr (rd_ptr),
        .rdata (rd_data),
        .we    (w_hs && !rst),
        .waddr (wr_ptr),
        .wstrb (bus.wstrb_s),
        .wdata (bus.wdata_s)
    );

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: transaction-level memory model checked every cycle plus literal checks.
module tb_axi_slave_mem;
    import axi_slave_mem_pkg::*;

    localparam int LW  = 4;
    localparam int NW  = 1 << LW;
    localparam int IDW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_slave_mem_if #(.ID_W(IDW)) bus ();
    axi_slave_mem #(.LOG_WORDS(LW), .ID_W(IDW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endfunction

    // Model: expected read beats as a queue, memory image with per-byte known flags, write progress.
    typedef struct {
        int             word;
        logic [IDW-1:0] id;
        logic           err;
        logic           last;
    } rbeat_t;

    rbeat_t         rq[$];
    logic [511:0]   m_mem   [NW];
    logic [63:0]    m_known [NW];
    int             w_left = 0;
    int             w_word = 0;
    logic [IDW-1:0] w_id   = '0;
    logic           w_err  = 1'b0;
    logic           b_pend = 1'b0;

    initial begin
        for (int i = 0; i < NW; i++) begin
            m_mem[i]   = '0;
            m_known[i] = '0;
        end
    end

    always @(posedge clk) begin : model
        int base;
        if (rst) begin
            rq.delete();
            w_left = 0;
            b_pend = 1'b0;
            w_err  = 1'b0;
        end else begin
            if (rq.size() != 0) begin
                if (bus.rready_s) void'(rq.pop_front());
            end else if (bus.arvalid_s) begin
                base = int'((bus.araddr_s >> 6) & 64'(NW - 1));
                for (int i = 0; i <= int'(bus.arlen_s); i++)
                    rq.push_back('{word: (base + i) % NW, id: bus.arid_s,
                                   err: (bus.arsize_s != 3'b110), last: (i == int'(bus.arlen_s))});
            end
            if (w_left > 0) begin
                if (bus.wvalid_s) begin
                    for (int b = 0; b < 64; b++) begin
                        if (bus.wstrb_s[b]) begin
                            m_mem[w_word][b*8 +: 8] = bus.wdata_s[b*8 +: 8];
                            m_known[w_word][b]      = 1'b1;
                        end
                    end
                    if (bus.wlast_s != (w_left == 1)) w_err = 1'b1;
                    w_word = (w_word + 1) % NW;
                    w_left--;
                    if (w_left == 0) b_pend = 1'b1;
                end
            end else if (b_pend) begin
                if (bus.bready_s) b_pend = 1'b0;
            end else if (bus.awvalid_s) begin
                w_id   = bus.awid_s;
                w_word = int'((bus.awaddr_s >> 6) & 64'(NW - 1));
                w_left = int'(bus.awlen_s) + 1;
                w_err  = (bus.awsize_s != 3'b110);
            end
        end
    end

    always @(negedge clk) begin : compare
        rbeat_t       e;
        logic [511:0] mask;
        chk("arready", 512'(bus.arready_s), 512'(rq.size() == 0));
        chk("rvalid",  512'(bus.rvalid_s),  512'(rq.size() != 0));
        chk("awready", 512'(bus.awready_s), 512'(w_left == 0 && !b_pend));
        chk("wready",  512'(bus.wready_s),  512'(w_left > 0));
        chk("bvalid",  512'(bus.bvalid_s),  512'(b_pend));
        if (rq.size() != 0) begin
            e = rq[0];
            for (int b = 0; b < 64; b++) mask[b*8 +: 8] = {8{m_known[e.word][b]}};
            chk("rdata", bus.rdata_s & mask, m_mem[e.word] & mask);
            chk("rid",   512'(bus.rid_s),   512'(e.id));
            chk("rresp", 512'(bus.rresp_s), e.err ? 512'd2 : 512'd0);
            chk("rlast", 512'(bus.rlast_s), 512'(e.last));
        end
        if (b_pend) begin
            chk("bid",   512'(bus.bid_s),   512'(w_id));
            chk("bresp", 512'(bus.bresp_s), w_err ? 512'd2 : 512'd0);
        end
    end

    logic [511:0] wd [256];
    logic [63:0]  ws [256];
    logic         wl [256];
    logic [511:0] cd [256];
    logic [1:0]   cr [256];
    logic         cl [256];
    int           cc [256];
    int           ncap;
    logic [1:0]   last_bresp;

    task automatic ar_hs(input logic [63:0] addr, input int len, input logic [2:0] size, input logic [IDW-1:0] id);
        logic hs;
        int   budget = 0;
        bus.arid_s = id; bus.araddr_s = addr; bus.arlen_s = 8'(len); bus.arsize_s = size; bus.arvalid_s = 1'b1;
        do begin
            @(negedge clk); hs = bus.arready_s;
            @(posedge clk); #1; budget++;
        end while (!hs && budget < 200);
        bus.arvalid_s = 1'b0;
        if (!hs) chk("ar_timeout", 512'(hs), 512'(1));
    endtask

    task automatic read_burst(input logic [63:0] addr, input int len, input logic [2:0] size,
                              input logic [IDW-1:0] id, input bit toggle);
        int cyc = 0;
        ar_hs(addr, len, size, id);
        ncap = 0;
        while (ncap <= len && cyc < 2000) begin
            bus.rready_s = toggle ? (cyc % 3 != 1) : 1'b1;
            @(negedge clk);
            if (bus.rvalid_s && bus.rready_s) begin
                cd[ncap] = bus.rdata_s; cr[ncap] = bus.rresp_s; cl[ncap] = bus.rlast_s; cc[ncap] = cyc;
                ncap++;
            end
            @(posedge clk); #1; cyc++;
        end
        bus.rready_s = 1'b0;
        chk("r_beat_count", 512'(ncap), 512'(len + 1));
    endtask

    task automatic write_burst(input logic [63:0] addr, input int len, input logic [2:0] size, input logic [IDW-1:0] id);
        logic hs;
        int   budget = 0;
        bus.awid_s = id; bus.awaddr_s = addr; bus.awlen_s = 8'(len); bus.awsize_s = size; bus.awvalid_s = 1'b1;
        do begin
            @(negedge clk); hs = bus.awready_s;
            @(posedge clk); #1; budget++;
        end while (!hs && budget < 200);
        bus.awvalid_s = 1'b0;
        if (!hs) chk("aw_timeout", 512'(hs), 512'(1));
        for (int i = 0; i <= len; i++) begin
            bus.wdata_s = wd[i]; bus.wstrb_s = ws[i]; bus.wlast_s = wl[i];
            bus.wid_s = 16'hBEEF ^ 16'(i); bus.wvalid_s = 1'b1;
            budget = 0;
            do begin
                @(negedge clk); hs = bus.wready_s;
                @(posedge clk); #1; budget++;
            end while (!hs && budget < 200);
            if (!hs) chk("w_timeout", 512'(hs), 512'(1));
        end
        bus.wvalid_s = 1'b0; bus.wlast_s = 1'b0;
        bus.bready_s = 1'b1;
        budget = 0;
        do begin
            @(negedge clk); hs = bus.bvalid_s;
            if (hs) last_bresp = bus.bresp_s;
            @(posedge clk); #1; budget++;
        end while (!hs && budget < 200);
        bus.bready_s = 1'b0;
        if (!hs) chk("b_timeout", 512'(hs), 512'(1));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        bus.arid_s = '0; bus.araddr_s = '0; bus.arlen_s = '0; bus.arsize_s = '0; bus.arvalid_s = 1'b0;
        bus.rready_s = 1'b0;
        bus.awid_s = '0; bus.awaddr_s = '0; bus.awlen_s = '0; bus.awsize_s = '0; bus.awvalid_s = 1'b0;
        bus.wid_s = '0; bus.wdata_s = '0; bus.wstrb_s = '0; bus.wlast_s = 1'b0; bus.wvalid_s = 1'b0;
        bus.bready_s = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_arready", 512'(bus.arready_s), 512'(1));
        chk("rst_awready", 512'(bus.awready_s), 512'(1));
        chk("rst_rvalid",  512'(bus.rvalid_s),  512'(0));
        chk("rst_wready",  512'(bus.wready_s),  512'(0));
        chk("rst_bvalid",  512'(bus.bvalid_s),  512'(0));
        chk("rst_rid",     512'(bus.rid_s),     512'(0));
        chk("rst_bid",     512'(bus.bid_s),     512'(0));
        chk("rst_rresp",   512'(bus.rresp_s),   512'(0));
        chk("rst_bresp",   512'(bus.bresp_s),   512'(0));
        chk("rst_rlast",   512'(bus.rlast_s),   512'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_arready", 512'(bus.arready_s), 512'(1));
        chk("post_rst_awready", 512'(bus.awready_s), 512'(1));
        @(posedge clk); #1;

        // Four-beat write then read at 0x40 (words 1..4).
        for (int k = 0; k < 4; k++) begin
            wd[k] = {64{8'hA0 + 8'(k)}}; ws[k] = '1; wl[k] = (k == 3);
        end
        write_burst(64'h40, 3, 3'b110, 16'h1234);
        chk("t1_bresp", 512'(last_bresp), 512'(0));
        read_burst(64'h40, 3, 3'b110, 16'h0055, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("t1_rdata", cd[k], {64{8'hA0 + 8'(k)}});
            chk("t1_rlast", 512'(cl[k]), 512'(k == 3));
            chk("t1_rresp", 512'(cr[k]), 512'(0));
        end
        chk("t1_first_beat_cycle", 512'(cc[0]), 512'(0));
        chk("t1_last_beat_cycle",  512'(cc[3]), 512'(3));

        // Byte-strobe merge on word 5; low address bits ignored on the read.
        wd[0] = '1; ws[0] = '1; wl[0] = 1'b1;
        write_burst(64'h140, 0, 3'b110, 16'h0002);
        wd[0] = '0; ws[0] = 64'h1; wl[0] = 1'b1;
        write_burst(64'h140, 0, 3'b110, 16'h0003);
        read_burst(64'h17F, 0, 3'b110, 16'h0004, 1'b0);
        chk("t2_strobe_merge", cd[0], {{63{8'hFF}}, 8'h00});

        // Wrong arsize: both beats SLVERR, rlast only on the second.
        read_burst(64'h40, 1, 3'b101, 16'h0007, 1'b0);
        chk("t3_rresp0", 512'(cr[0]), 512'(2));
        chk("t3_rresp1", 512'(cr[1]), 512'(2));
        chk("t3_rlast0", 512'(cl[0]), 512'(0));
        chk("t3_rlast1", 512'(cl[1]), 512'(1));

        // Early wlast: both beats still written, response SLVERR.
        wd[0] = {64{8'h11}}; ws[0] = '1; wl[0] = 1'b1;
        wd[1] = {64{8'h22}}; ws[1] = '1; wl[1] = 1'b0;
        write_burst(64'h180, 1, 3'b110, 16'h0BAD);
        chk("t4_bresp", 512'(last_bresp), 512'(2));
        read_burst(64'h180, 1, 3'b110, 16'h0008, 1'b0);
        chk("t4_word6", cd[0], {64{8'h11}});
        chk("t4_word7", cd[1], {64{8'h22}});

        // rready toggling: no lost or duplicated beats.
        read_burst(64'h40, 3, 3'b110, 16'h0009, 1'b1);
        for (int k = 0; k < 4; k++) chk("t4_toggle_rdata", cd[k], {64{8'hA0 + 8'(k)}});

        // Wrap from word 15, with address bits above the word index set.
        for (int k = 0; k < 3; k++) begin
            wd[k] = {64{8'hC0 + 8'(k)}}; ws[k] = '1; wl[k] = (k == 2);
        end
        write_burst(64'h3C0, 2, 3'b110, 16'h000A);
        read_burst(64'hABCD_0000_0000_FFC0, 2, 3'b110, 16'h000B, 1'b0);
        for (int k = 0; k < 3; k++) chk("t5_wrap_rdata", cd[k], {64{8'hC0 + 8'(k)}});

        // Concurrent read and write of word 2 in the same cycle: old data first, new data later.
        wd[0] = {64{8'h5A}}; ws[0] = '1; wl[0] = 1'b1;
        fork
            write_burst(64'h80, 0, 3'b110, 16'h000C);
            read_burst(64'h80, 0, 3'b110, 16'h000D, 1'b0);
        join
        chk("t6_same_cycle_old", cd[0], {64{8'hA1}});
        read_burst(64'h80, 0, 3'b110, 16'h000E, 1'b0);
        chk("t6_later_new", cd[0], {64{8'h5A}});

        // 256-beat bursts via the 9-bit counter.
        for (int i = 0; i < 256; i++) begin
            wd[i] = {16{32'(i)}}; ws[i] = '1; wl[i] = (i == 255);
        end
        write_burst(64'h0, 255, 3'b110, 16'h00FF);
        chk("t7_bresp", 512'(last_bresp), 512'(0));
        read_burst(64'h0, 255, 3'b110, 16'h0100, 1'b0);
        chk("t7_first", cd[0],   {16{32'd240}});
        chk("t7_last",  cd[255], {16{32'd255}});
        chk("t7_rlast", 512'(cl[255]), 512'(1));

        // Reset during beat 2 of an 8-beat read.
        ar_hs(64'h0, 7, 3'b110, 16'h0200);
        bus.rready_s = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t8_beat2_valid", 512'(bus.rvalid_s), 512'(1));
        @(posedge clk); #1;
        rst = 1'b0; bus.rready_s = 1'b0;
        @(negedge clk);
        chk("t8_rvalid_after_rst",  512'(bus.rvalid_s),  512'(0));
        chk("t8_arready_after_rst", 512'(bus.arready_s), 512'(1));
        chk("t8_awready_after_rst", 512'(bus.awready_s), 512'(1));
        @(posedge clk); #1;
        read_burst(64'h180, 1, 3'b110, 16'h0201, 1'b0);
        chk("t8_retained6", cd[0], {16{32'd246}});
        chk("t8_retained7", cd[1], {16{32'd247}});

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 SHALL have parameter LOG_WORDS, default 10: memory depth is 2^LOG_WORDS words of 512 bits.
REQ-002 SHALL have parameter ID_W, default 16: width of all ID fields.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 arid_s/araddr_s/arlen_s/arsize_s/arvalid_s  input  ID_W/64/8/3/1  read address channel.
REQ-006 arready_s  output  1  read address accept.
REQ-007 rid_s/rdata_s/rresp_s/rlast_s/rvalid_s  output  ID_W/512/2/1/1  read data channel.
REQ-008 rready_s  input  1  read data accept.
REQ-009 awid_s/awaddr_s/awlen_s/awsize_s/awvalid_s  input  ID_W/64/8/3/1  write address channel.
REQ-010 awready_s  output  1  write address accept.
REQ-011 wid_s/wdata_s/wstrb_s/wlast_s/wvalid_s  input  ID_W/512/64/1/1  write data channel; wid_s is ignored.
REQ-012 wready_s  output  1  write data accept.
REQ-013 bid_s/bresp_s/bvalid_s  output  ID_W/2/1  write response channel.
REQ-014 bready_s  input  1  write response accept.

Function
REQ-015 Read FSM SHALL use states R_IDLE and R_BURST; arready_s = 1 only in R_IDLE.
REQ-016 On arvalid_s&&arready_s: latch arid_s, word pointer = araddr_s[LOG_WORDS+5:6], beats = arlen_s+1, err = (arsize_s != 3'b110); go to R_BURST.
REQ-017 In R_BURST: rvalid_s = 1, rdata_s = mem[pointer] (combinational read), rid_s = latched ID, rresp_s = 2'b10 if err else 2'b00, rlast_s = 1 on final beat.
REQ-018 First R beat SHALL be valid the cycle after AR handshake; with rready_s held high, one beat per cycle.
REQ-019 On rvalid_s&&rready_s: pointer+1, beats-1; after the final beat return to R_IDLE; rdata_s/rresp_s/rlast_s SHALL hold stable while rvalid_s&&!rready_s.
REQ-020 Write FSM SHALL use states W_IDLE, W_DATA, W_RESP; awready_s = 1 only in W_IDLE, wready_s = 1 only in W_DATA.
REQ-021 On AW handshake: latch awid_s, pointer, beats = awlen_s+1, err = (awsize_s != 3'b110); go to W_DATA.
REQ-022 Each W handshake SHALL write byte i of mem[pointer] iff wstrb_s[i], then pointer+1, beats-1.
REQ-023 err SHALL be set if wlast_s disagrees with (beats==1) on any beat; termination SHALL follow the beat count, not wlast_s.
REQ-024 After the final W beat: go to W_RESP; bvalid_s = 1, bid_s = latched ID, bresp_s = 2'b10 if err else 2'b00; return to W_IDLE on bready_s.
REQ-025 Pointers SHALL wrap modulo 2^LOG_WORDS; address bits above LOG_WORDS+5 and [5:0] are ignored; no 4 KB boundary check.
REQ-026 Read and write FSMs SHALL run concurrently and independently; one outstanding transaction per direction.
REQ-027 Same-word read and write in the same cycle: R beat returns old data; a write is visible to any R beat presented in a later cycle.
REQ-028 AR/AW handshake with arlen/awlen = 255 SHALL produce 256 beats; the 8-bit length plus 1 is held in a 9-bit counter.

Reset
REQ-029 rst SHALL force R_IDLE and W_IDLE, all valid outputs 0, rid_s/bid_s/rresp_s/bresp_s/rlast_s 0, counters and pointers 0.
REQ-030 rst mid-burst SHALL abort the transaction with no further beats or response; memory contents SHALL be retained, not cleared.
REQ-031 In the cycle after rst deasserts, arready_s = awready_s = 1.

Structure
REQ-032 A shared package SHALL hold RESP_OKAY=2'b00, RESP_SLVERR=2'b10, SIZE_64B=3'b110, and the read and write state enums.
REQ-033 The memory array SHALL be one sub-module, axi_sm_ram: one asynchronous read port, one byte-enabled synchronous write port.

Verification
REQ-034 AW addr 0x40, len 3, 4 beats of pattern k, full strobe -> bresp 0; AR addr 0x40, len 3 -> 4 beats of data k, rlast on beat 4, rresp 0.
REQ-035 Write word 5 = all 0xFF, then wstrb 0x1 with data 0 -> read word 5 returns byte0 = 0x00, other bytes 0xFF.
REQ-036 AR with arsize 3'b101, len 1 -> 2 beats each rresp 2'b10, rlast only on beat 2.
REQ-037 AW len 1 with wlast on beat 1 -> 2 beats accepted, bresp 2'b10; rready_s toggling during a read -> data stable, no lost or duplicated beats.
REQ-038 LOG_WORDS=4, AR at word 15, len 2 -> words 15, 0, 1 returned (wrap).
REQ-039 rst asserted on beat 2 of an 8-beat read -> rvalid_s 0 the next cycle, arready_s 1; previously written data still readable.
